clk_div_rst_gen: RTL and testbench
==================================

Name: clk_div_rst_gen

Overview:
- Parametrised successor to the fixed divide-by-2 core clock generator in the FPGA top.
- Provides NUM_CH independent clock channels. Each channel divides clk_i by a runtime-programmable ratio and also emits a one-cycle enable strobe.
- Divisor changes take effect only at period boundaries, so the divided clock never glitches.
- Also generates a reset for the SoC: asserted asynchronously, released synchronously, then stretched by a counter.
- Sits between the board clock/reset pins and rv32i_soc.

Parameters:
- NUM_CH, 2, number of divider channels (1..8).
- DIV_W, 8, width of each channel's divisor field.
- RST_HOLD, 16, extra clk_i cycles rst_n_o stays low after the synchroniser releases (0 allowed).
- DEF_DIV, 2, divisor loaded into every channel's active register at reset.

Ports:
- clk_i  input  1  source clock.
- reset_n  input  1  asynchronous, active-low reset.
- div_i  input  NUM_CH*DIV_W  requested divisor per channel; channel c uses bits [c*DIV_W +: DIV_W].
- en_i  input  NUM_CH  per-channel run enable.
- clk_o  output  NUM_CH  divided clocks (flop outputs).
- stb_o  output  NUM_CH  one-cycle pulse in the cycle a divided clock rises.
- busy_o  output  NUM_CH  channel is running (not idle).
- rst_n_o  output  1  synchronised, stretched active-low reset for the SoC.

Behaviour:
- Reset (reset_n low, async): all outputs 0. Each channel's cnt_q = 0, D_act = DEF_DIV, state IDLE. Reset-stretch counter cleared.
- Divisor sanitising: D = div_i field; any value < 2 is treated as 2. L = D - (D>>1), H = D>>1. Odd D gives the longer low phase (D=3 → low 2, high 1).
- Per-channel state machine, states IDLE and RUN:
  - IDLE: cnt_q held at 0; clk_o = 0; stb_o = 0; busy_o = 0. When en_i[c] is sampled 1: load D_act = sanitised div_i and go to RUN with cnt_q = 0 (one low cycle already under way).
  - RUN: cnt_q increments each cycle. When cnt_q == D_act-1 (wrap):
    - if en_i[c] = 1: cnt_q ← 0 and D_act ← sanitised div_i (boundary load);
    - else: go to IDLE with cnt_q ← 0.
  - busy_o = 1 in RUN.
- Output relations, enforced every cycle; implement as flops fed from next-state values, with no combinational path from cnt_q to the pin:
  - clk_o[c] == (state == RUN && cnt_q >= L_act)
  - stb_o[c] == (state == RUN && cnt_q == L_act)
- D = 2 reproduces the legacy waveform: clk_o toggles every clk_i cycle, first high in the 2nd cycle after enable.
- Divisor writes mid-period are ignored until the next wrap. Multiple writes within one period: the value present on the wrap cycle wins.
- en_i deasserted mid-period: the current period completes in full, so the high phase is never truncated. en_i re-asserted before the wrap: no stop occurs.
- Reset path:
  - 2-flop synchroniser on reset_n, async clear, D input tied to 1.
  - After the synchroniser output goes high, a counter runs RST_HOLD cycles, then rst_n_o ← 1. rst_n_o rises exactly RST_HOLD+2 clk_i edges after reset_n deasserts.
  - reset_n low at any time, including mid-count: rst_n_o = 0 immediately and the count restarts.
- Channels are independent of rst_n_o; they are gated only by reset_n and en_i.
- Counter widths are DIV_W bits and $clog2(RST_HOLD+1) bits. No overflow is possible because D ≤ 2^DIV_W − 1.

Decomposition:
- Package clk_div_pkg:
  - DIV_MIN = 2;
  - typedef enum {CH_IDLE, CH_RUN} ch_state_e;
  - function sanitise_div();
  - functions low_len() and high_len().
- One sub-module clk_div_ch (one divider channel: state, counter, D_act, clk_o/stb_o/busy_o flops), instantiated NUM_CH times via generate.
- Reset synchroniser and stretch counter stay inline in the top.

Test Plan:
- Legacy match: DEF_DIV=2, en_i[0]=1 after reset → clk_o[0] = 0,1,0,1…; stb_o[0] high on each high cycle; period 2.
- Odd divide: div_i ch1 = 5, en_i[1] = 1 → clk_o[1] repeating 0,0,0,1,1 (L=3, H=2); stb_o[1] one cycle at each rise; busy_o[1] = 1.
- Glitch-free change: ch0 running at D=4; write div_i = 6 at cnt_q = 1 → remaining period stays 4 cycles (low 2, high 2); next period is 6 cycles (low 3, high 3).
- Clamp and stop: div_i = 0 → behaves as D=2. Drop en_i during a high phase → high completes, clk_o returns to 0 at the wrap, busy_o falls, cnt_q = 0.
- Reset stretch: RST_HOLD=16, release reset_n → rst_n_o rises exactly 18 clk_i edges later. Pulse reset_n low at edge 10 → rst_n_o stays 0 and the count restarts from the new release.
- Async reset mid-run: assert reset_n mid-high-phase → clk_o, stb_o, busy_o all 0 immediately, without waiting for a clk_i edge. After release, channels are IDLE until en_i is sampled.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state type, constants and divisor helpers
// for the clk_div_rst_gen clock/reset block.
package clk_div_pkg;

    localparam int unsigned DIV_MIN = 2;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    // Divisors below DIV_MIN cannot form a high and a low phase.
    function automatic int unsigned sanitise_div(input int unsigned d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    // Odd divisors put the extra cycle in the low phase.
    function automatic int unsigned low_len(input int unsigned d);
        return d - (d >> 1);
    endfunction

    function automatic int unsigned high_len(input int unsigned d);
        return d >> 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel; divisor reloads only at wrap.
// Ports: clk_i, reset_n, div_i, en_i in; clk_o, stb_o, busy_o out.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div_i,
    input  logic             en_i,
    output logic             clk_o,
    output logic             stb_o,
    output logic             busy_o
);

    localparam logic [0:0] ST_IDLE = CH_IDLE;
    localparam logic [0:0] ST_RUN  = CH_RUN;

    localparam logic [DIV_W-1:0] D_RST =
        DIV_W'(sanitise_div(DEF_DIV));

    logic [0:0]       st_q, st_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] dact_q, dact_d;
    logic [DIV_W-1:0] div_s;
    logic [DIV_W-1:0] low_d;
    logic             wrap;
    logic             run_d;

    always_comb begin
        div_s  = DIV_W'(sanitise_div(32'(div_i)));
        wrap   = (cnt_q == dact_q - DIV_W'(1));
        st_d   = st_q;
        cnt_d  = cnt_q;
        dact_d = dact_q;
        unique case (1'b1)
            (st_q == ST_IDLE): begin
                cnt_d = '0;
                if (en_i) begin
                    st_d   = ST_RUN;
                    dact_d = div_s;
                end
            end
            (st_q == ST_RUN): begin
                if (wrap) begin
                    cnt_d = '0;
                    if (en_i) dact_d = div_s;
                    else      st_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: st_d = ST_IDLE;
        endcase
        // Pins are registered from next-state values so they
        // line up with cnt_q without a comb path to the pin.
        low_d = DIV_W'(low_len(32'(dact_d)));
        run_d = (st_d == ST_RUN);
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            dact_q <= D_RST;
            clk_o  <= 1'b0;
            stb_o  <= 1'b0;
            busy_o <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            dact_q <= dact_d;
            clk_o  <= run_d && (cnt_d >= low_d);
            stb_o  <= run_d && (cnt_d == low_d);
            busy_o <= run_d;
        end
    end

endmodule

// File: rtl/clk_div_rst_gen.sv
// clk_div_rst_gen: NUM_CH glitch-free clock dividers plus SoC reset.
// Ports: clk_i, reset_n, div_i, en_i in; clk_o, stb_o, busy_o, rst_n_o out.
module clk_div_rst_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned RST_HOLD = 16,
    parameter int unsigned DEF_DIV  = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_n,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic [NUM_CH-1:0]       en_i,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       stb_o,
    output logic [NUM_CH-1:0]       busy_o,
    output logic                    rst_n_o
);

    localparam int unsigned HW =
        (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD = HW'(RST_HOLD);

    logic [1:0]    sync_q;
    logic [HW-1:0] hold_q, hold_d;

    always_comb begin
        hold_d = hold_q;
        if (sync_q[1] && (hold_q != HOLD))
            hold_d = hold_q + HW'(1);
    end

    // rst_n_o is registered from the next hold count so that it
    // rises RST_HOLD+2 edges after release, even for RST_HOLD=0.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            hold_q  <= '0;
            rst_n_o <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], 1'b1};
            hold_q  <= hold_d;
            rst_n_o <= sync_q[0] && (hold_d == HOLD);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_div_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk_i   (clk_i),
            .reset_n (reset_n),
            .div_i   (div_i[c*DIV_W +: DIV_W]),
            .en_i    (en_i[c]),
            .clk_o   (clk_o[c]),
            .stb_o   (stb_o[c]),
            .busy_o  (busy_o[c])
        );
    end

endmodule

// File: tb/tb_clk_div_rst_gen.sv
// tb_clk_div_rst_gen: directed plus random stimulus for clk_div_rst_gen,
// checked against a waveform-queue reference model.
module tb_clk_div_rst_gen;

    localparam int NUM_CH   = 2;
    localparam int DIV_W    = 8;
    localparam int RST_HOLD = 16;
    localparam int DEF_DIV  = 2;

    logic                    clk_i = 1'b0;
    logic                    reset_n;
    logic [NUM_CH*DIV_W-1:0] div_i;
    logic [NUM_CH-1:0]       en_i;
    logic [NUM_CH-1:0]       clk_o;
    logic [NUM_CH-1:0]       stb_o;
    logic [NUM_CH-1:0]       busy_o;
    logic                    rst_n_o;

    int errors = 0;
    int checks = 0;

    // Per channel: queue of {clk,stb} for the remaining cycles of
    // the period in progress.
    logic [1:0] mq [NUM_CH][$];
    logic       e_clk  [NUM_CH];
    logic       e_stb  [NUM_CH];
    logic       e_busy [NUM_CH];
    int         rst_edges;

    clk_div_rst_gen #(
        .NUM_CH   (NUM_CH),
        .DIV_W    (DIV_W),
        .RST_HOLD (RST_HOLD),
        .DEF_DIV  (DEF_DIV)
    ) dut (
        .clk_i    (clk_i),
        .reset_n  (reset_n),
        .div_i    (div_i),
        .en_i     (en_i),
        .clk_o    (clk_o),
        .stb_o    (stb_o),
        .busy_o   (busy_o),
        .rst_n_o  (rst_n_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int idx,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h",
                   tag, idx, obs, exp);
        end
    endtask

    task automatic set_div(input int c, input int v);
        div_i[c*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    task automatic reset_assert();
        reset_n = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            mq[c].delete();
            e_clk[c]  = 1'b0;
            e_stb[c]  = 1'b0;
            e_busy[c] = 1'b0;
        end
        rst_edges = 0;
    endtask

    task automatic model_ch(input int c);
        int d;
        int l;
        int h;
        logic [1:0] cur;
        if (mq[c].size() == 0 && en_i[c]) begin
            d = int'(div_i[c*DIV_W +: DIV_W]);
            if (d < 2) d = 2;
            l = d - d / 2;
            h = d / 2;
            repeat (l) mq[c].push_back(2'b00);
            mq[c].push_back(2'b11);
            repeat (h - 1) mq[c].push_back(2'b10);
        end
        if (mq[c].size() != 0) begin
            cur = mq[c].pop_front();
            e_busy[c] = 1'b1;
        end else begin
            cur = 2'b00;
            e_busy[c] = 1'b0;
        end
        e_clk[c] = cur[1];
        e_stb[c] = cur[0];
    endtask

    task automatic check_all();
        for (int c = 0; c < NUM_CH; c++) begin
            chk("clk_o",  c, 32'(clk_o[c]),  32'(e_clk[c]));
            chk("stb_o",  c, 32'(stb_o[c]),  32'(e_stb[c]));
            chk("busy_o", c, 32'(busy_o[c]), 32'(e_busy[c]));
        end
        chk("rst_n_o", 0, 32'(rst_n_o),
            32'(reset_n && (rst_edges >= RST_HOLD + 2)));
    endtask

    task automatic step();
        @(posedge clk_i);
        if (reset_n) begin
            if (rst_edges < 1000) rst_edges++;
            for (int c = 0; c < NUM_CH; c++) model_ch(c);
        end
        #1;
        check_all();
        @(negedge clk_i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int first;
        int found;
        logic [9:0] pc;
        logic [9:0] ps;

        en_i  = '0;
        div_i = '0;
        reset_assert();
        #1;
        check_all();
        repeat (3) step();

        // Release: rst_n_o must rise RST_HOLD+2 edges later.
        reset_n = 1'b1;
        first = -1;
        for (int i = 1; i <= 22; i++) begin
            step();
            if (rst_n_o && first < 0) first = i;
        end
        chk("rst_release_edge", 0, first, RST_HOLD + 2);

        // Legacy divide-by-2 on ch0.
        set_div(0, 2);
        en_i[0] = 1'b1;
        pc = '0;
        ps = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            pc = {pc[8:0], clk_o[0]};
            ps = {ps[8:0], stb_o[0]};
        end
        chk("legacy_clk", 0, 32'(pc[5:0]), 32'(6'b010101));
        chk("legacy_stb", 0, 32'(ps[5:0]), 32'(6'b010101));

        // Odd divide-by-5 on ch1.
        set_div(1, 5);
        en_i[1] = 1'b1;
        pc = '0;
        ps = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            pc = {pc[8:0], clk_o[1]};
            ps = {ps[8:0], stb_o[1]};
        end
        chk("odd_clk", 1, 32'(pc), 32'(10'b0001100011));
        chk("odd_stb", 1, 32'(ps), 32'(10'b0001000010));

        // Stop ch0, restart at 4, rewrite to 6 at count 1.
        en_i[0] = 1'b0;
        for (int i = 0; i < 20 && e_busy[0]; i++) step();
        chk("ch0_stopped", 0, 32'(busy_o[0]), 32'd0);
        set_div(0, 4);
        en_i[0] = 1'b1;
        step();
        step();
        set_div(0, 6);
        pc = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            pc = {pc[8:0], clk_o[0]};
        end
        chk("glitch_free", 0, 32'(pc[7:0]), 32'(8'b11000111));

        // Clamp 0 -> 2, then drop en in the final high cycle.
        set_div(0, 0);
        repeat (10) step();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (e_clk[0] && mq[0].size() == 0) found = 1;
        end
        chk("found_high", 0, found, 1);
        en_i[0] = 1'b0;
        step();
        chk("stop_clk", 0, 32'(clk_o[0]), 32'd0);
        chk("stop_busy", 0, 32'(busy_o[0]), 32'd0);

        // Async reset while ch1 strobes high.
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (e_stb[1]) found = 1;
        end
        chk("found_stb", 1, found, 1);
        en_i = '0;
        reset_assert();
        #1;
        check_all();
        chk("async_clk", 1, 32'(clk_o[1]), 32'd0);
        @(negedge clk_i);
        repeat (2) step();

        // Release, pulse reset at edge 10, count restarts.
        reset_n = 1'b1;
        repeat (10) step();
        reset_assert();
        #1;
        chk("pulse_rst", 0, 32'(rst_n_o), 32'd0);
        #2;
        reset_n = 1'b1;
        first = -1;
        for (int i = 1; i <= 22; i++) begin
            step();
            if (rst_n_o && first < 0) first = i;
            if (i == 3) begin
                chk("idle_after_rst", 1, 32'(busy_o[1]), 32'd0);
                set_div(1, 3);
                en_i[1] = 1'b1;
            end
        end
        chk("rst_restart_edge", 0, first, RST_HOLD + 2);

        // Random phase.
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(7) == 0) en_i[c] = ~en_i[c];
                if ($urandom_range(3) == 0)
                    set_div(c, int'($urandom_range(9)));
            end
            if (k == 300) begin
                reset_assert();
                #1;
                check_all();
                #2;
                reset_n = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
